// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment display driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_MINUS = 7'h3F;
  localparam seg_t SEG_BLANK = 7'h7F;

  // Scan position; digit 0 is the rightmost digit.
  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } scan_idx_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment pattern.
// Non-decimal codes (10-15) show nothing rather than a hex glyph.
module bcd_to_seg
  import seg_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg
);

  // Lookup of the glyph for one decimal digit.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed common-anode display driver. A BCD word is
// captured into shadow registers on load, then each digit is enabled in
// turn for REFRESH_DIV cycles with optional leading-zero blanking and a
// minus sign in the leftmost position.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic        load,
  input  logic        neg,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0]      div_cnt;
  logic                  tick;
  scan_idx_t             idx;

  logic [15:0]           sh_digits;
  logic                  sh_neg;
  logic                  sh_lz;

  bcd_t                  nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] is_zero;
  logic [NUM_DIGITS-1:0] lead_zero;

  bcd_t                  sel_nib;
  seg_t                  dec_seg;
  seg_t                  seg_next;

  // Refresh divider; the wrap cycle advances the scan.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == CNT_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == CNT_LAST);

  // Shadow copy of the input word so a frame never mixes old and new digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_digits <= '0;
      sh_neg    <= 1'b0;
      sh_lz     <= 1'b0;
    end else if (load) begin
      sh_digits <= digits;
      sh_neg    <= neg;
      sh_lz     <= blank_lz;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign nib[gi]     = sh_digits[gi*4 +: 4];
      assign is_zero[gi] = (sh_digits[gi*4 +: 4] == 4'd0);
    end
  endgenerate

  // A digit is a leading zero when it and everything to its left are zero.
  // When a minus sign occupies digit 3, that position no longer blocks the
  // blanking of digit 2, so "-  7" rather than "-0 7".
  assign lead_zero[3] = is_zero[3] & ~sh_neg;
  assign lead_zero[2] = is_zero[2] & (is_zero[3] | sh_neg);
  assign lead_zero[1] = is_zero[1] & lead_zero[2];
  assign lead_zero[0] = 1'b0;

  assign sel_nib = nib[idx];

  bcd_to_seg u_bcd_to_seg (
    .bcd (sel_nib),
    .seg (dec_seg)
  );

  // Override priority: minus sign, then leading-zero blank, then glyph.
  always_comb begin
    seg_next = dec_seg;
    if ((idx == DIG3) && sh_neg) begin
      seg_next = SEG_MINUS;
    end else if (lead_zero[idx] && sh_lz) begin
      seg_next = SEG_BLANK;
    end
  end

  // Scan FSM plus registered anode/segment outputs. Outputs are built from
  // the pre-edge idx, so they trail idx by one cycle and the anode is a
  // clean one-hot-low word every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= DIG0;
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      if (tick) begin
        case (idx)
          DIG0:    idx <= DIG1;
          DIG1:    idx <= DIG2;
          DIG2:    idx <= DIG3;
          default: idx <= DIG0;
        endcase
      end
      an  <= ~(4'b0001 << idx);
      seg <= seg_next;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with a short refresh period.
// Expected (anode, segment) pairs are queued as each word is loaded and
// retired as the scan reaches the matching digit.
module tb_seven_seg_scanner;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits = '0;
  logic        load = 1'b0;
  logic        neg = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  seven_seg_scanner #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .digits   (digits),
    .load     (load),
    .neg      (neg),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-14s got=%0h", tag, got);
    end else begin
      $display("FAIL %-14s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until the anode matches, bounded to a little over one frame.
  task automatic wait_an(input logic [3:0] exp_an, output bit found);
    for (int i = 0; i < 5 * DIV && an !== exp_an; i++) step();
    found = (an === exp_an);
    if (!found) chk("an_timeout", {28'd0, an}, {28'd0, exp_an});
  endtask

  // Expected glyphs for digits 3..0 of a word just loaded.
  task automatic push_frame(input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0);
    sb.push_back('{an: 4'b0111, seg: s3});
    sb.push_back('{an: 4'b1011, seg: s2});
    sb.push_back('{an: 4'b1101, seg: s1});
    sb.push_back('{an: 4'b1110, seg: s0});
  endtask

  task automatic drain();
    exp_t e;
    bit   found;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_an(e.an, found);
      if (found) begin
        chk($sformatf("seg@an=%b", e.an), {25'd0, seg}, {25'd0, e.seg});
        chk("an_onehot", $countones(~an), 1);
      end
    end
  endtask

  // Load lands at the first edge; the second edge shows the new data.
  task automatic load_word(input logic [15:0] d, input logic n, input logic lz);
    digits   = d;
    neg      = n;
    blank_lz = lz;
    load     = 1'b1;
    step();
    load = 1'b0;
    step();
  endtask

  initial begin
    logic [3:0] exp_an;
    bit         found;
    exp_t       e;

    // Power-on reset, then let the scan run briefly before resetting mid-frame.
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    #3;
    reset = 1'b1;
    #1;
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'h1);
    step();
    reset = 1'b0;

    // Scan restarts at digit 0, each digit held for DIV edges.
    for (int e_i = 1; e_i <= 4 * DIV + 1; e_i++) begin
      step();
      exp_an = ~(4'b0001 << (((e_i - 1) / DIV) % 4));
      chk($sformatf("scan_e%0d", e_i), {28'd0, an}, {28'd0, exp_an});
      if (e_i == 1) chk("first_seg", {25'd0, seg}, 32'h40);
    end

    // Plain decode.
    load_word(16'h1234, 1'b0, 1'b0);
    push_frame(7'h79, 7'h24, 7'h30, 7'h19);
    drain();

    // Leading-zero blanking.
    load_word(16'h0050, 1'b0, 1'b1);
    push_frame(7'h7F, 7'h7F, 7'h12, 7'h40);
    drain();
    load_word(16'h0000, 1'b0, 1'b1);
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h40);
    drain();

    // Minus sign with blanking.
    load_word(16'h0007, 1'b1, 1'b1);
    push_frame(7'h3F, 7'h7F, 7'h7F, 7'h78);
    drain();

    // Inputs change without load: display must not move.
    digits   = 16'hA000;
    neg      = 1'b0;
    blank_lz = 1'b0;
    for (int i = 0; i < 4 * DIV; i++) step();
    push_frame(7'h3F, 7'h7F, 7'h7F, 7'h78);
    drain();

    // Now capture it: invalid code blanks digit 3, zeros shown.
    load_word(16'hA000, 1'b0, 1'b0);
    push_frame(7'h7F, 7'h40, 7'h40, 7'h40);
    drain();

    // Load coinciding with the 0->1 tick: the next digit shows new data.
    wait_an(4'b0111, found);
    wait_an(4'b1110, found);
    step();
    step();
    digits = 16'h9999;
    load   = 1'b1;
    sb.push_back('{an: 4'b1101, seg: 7'h10});
    step();
    load = 1'b0;
    step();
    e = sb.pop_front();
    chk("tick_load_an", {28'd0, an}, {28'd0, e.an});
    chk("tick_load_seg", {25'd0, seg}, {25'd0, e.seg});
    chk("dp_idle", {31'd0, dp}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Multiplexed four-digit seven-segment display driver that consumes the 4-bit BCD digits produced by the calculator's digit-entry counters and result logic, and drives the board's common-anode display. It latches a 16-bit BCD word on a load strobe, scans the four digits at a fixed refresh rate, and decodes each digit to active-low segments. It also applies optional leading-zero blanking and a minus sign. It sits between the calculator datapath and the board pins.

## Interface
- REFRESH_DIV, default 100000: clock cycles each digit stays enabled (1 kHz per digit at 100 MHz); minimum 2.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- digits  in  16  four BCD nibbles; digits[15:12] = digit 3 (leftmost), digits[3:0] = digit 0 (rightmost).
- load  in  1  capture strobe; `digits`, `neg`, `blank_lz` are copied into the shadow registers on every rising clk edge where `load` = 1.
- neg  in  1  when set, digit 3 shows a minus sign.
- blank_lz  in  1  enables leading-zero blanking.
- an  out  4  anode enables, active-low, one-hot-low.
- seg  out  7  segments, active-low, {g,f,e,d,c,b,a}.
- dp  out  1  decimal point, active-low; always 1.

## Operation
- **Shadow registers** (`sh_digits`, `sh_neg`, `sh_lz`):
  - Loaded only on `load`, so the display never shows a partially updated word.
  - Hold their value otherwise.
- **Refresh counter** `div_cnt` counts 0 to REFRESH_DIV-1, then wraps to 0.
  - The wrap cycle is the tick.
- **Digit index** `idx` (2 bits) advances 0→1→2→3→0 on each tick.
  - It is a 4-state scan FSM with no other transitions.
- **Decode** of the selected nibble:
  - 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10.
  - 10–15 → 7'h7F (blank).
- **Override priority**, highest first, for the selected digit:
  1. idx=3 and `sh_neg` → 7'h3F (minus).
  2. Digit is a leading zero and `sh_lz` → 7'h7F.
  3. Otherwise, the decoded value.
- **Leading zero** definition:
  - Digit k (k = 1..3) is a leading zero when it and every higher digit are 0.
  - When `sh_neg` = 1, digit 3 is excluded from this check.
  - Digit 0 is never blanked.
- **Anode output:** `an` = ~(4'b0001 << idx).

## Timing
- **Reset values:**
  - `div_cnt`=0, `idx`=0, all shadow registers 0.
  - `an`=4'b1111, `seg`=7'h7F, `dp`=1.
- **Registered outputs:**
  - `an` and `seg` are registered from the current `idx` and the shadow registers, so they lag `idx` by 1 cycle.
  - First clock after reset release: `an`=4'b1110, `seg`=7'h40.
- **Load latency:**
  - A load at edge N updates the shadow registers at edge N.
  - The new pattern appears on `seg` at edge N+1 for the currently selected digit.
- **Scan period:**
  - Each digit is enabled for exactly REFRESH_DIV cycles.
  - The full frame is 4·REFRESH_DIV cycles.
- **Simultaneous events:**
  - `load` and a tick in the same cycle: both take effect.
  - The next digit is shown with the new data.
- **Load held high:** the shadow registers track the inputs every cycle.
- **Reset mid-scan:**
  - Outputs go to their reset values immediately (asynchronous).
  - The scan restarts at digit 0 with the full REFRESH_DIV dwell.
- **Glitch-free anode:** `an` never has more than one bit low in any cycle.

## Structure
- **Package `seg_pkg`:**
  - Constants SEG_0..SEG_9, SEG_MINUS, SEG_BLANK (7-bit, active-low).
  - NUM_DIGITS = 4.
  - Typedef `bcd_t` (4-bit).
- **Sub-module `bcd_to_seg`:**
  - Combinational nibble → 7-bit active-low pattern.
  - Values 10–15 map to blank.
  - Instantiated once, after the digit mux.
- **Top-level contents:** counter, scan FSM, shadow registers, leading-zero logic and output registers.

## Test plan
All scenarios use REFRESH_DIV=4.
- **Reset and first frame:** assert reset mid-frame → `an`=1111, `seg`=7F at once; release → next edge `an`=1110, `seg`=40; `an` steps 1101, 1011, 0111 at 4-cycle intervals.
- **Digit decode:** load `digits`=16'h1234, `blank_lz`=0, `neg`=0 → over one frame, `seg` per anode 1110/1101/1011/0111 = 19/30/24/79.
- **Leading-zero blanking:** load 16'h0050 with `blank_lz`=1 → digits 3,2 = 7F, digit 1 = 12, digit 0 = 40. Load 16'h0000 → digit 0 = 40, others 7F.
- **Minus sign:** load 16'h0007 with `neg`=1, `blank_lz`=1 → digit 3 = 3F, digits 2,1 = 7F, digit 0 = 78.
- **Invalid BCD and load gating:** `digits`=16'hA000 with `load`=0 → display unchanged. Pulse `load` → digit 3 = 7F.
- **Load on tick boundary:** pulse `load` with 16'h9999 in the cycle `idx` wraps 0→1 → the very next `seg` (digit 1) = 10.
